// File: rtl/writeback_queue_pkg.sv
// Shared constants and entry record for the register writeback queue.
// Consumers import this package; queue and forwarding logic size themselves from it.
package writeback_queue_pkg;

    localparam int QDepth    = 4;
    localparam int AddrWidth = 5;
    localparam int DataWidth = 32;

    typedef struct packed {
        logic [AddrWidth-1:0] regAddr;
        logic [DataWidth-1:0] data;
    } entry_t;

    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Handshake, register-file write and forwarding-snoop bundle of the writeback queue.
// slave is the queue side; master is the pipeline / register-file side.
interface writeback_queue_if
    import writeback_queue_pkg::*;
#(
    parameter int width        = DataWidth,
    parameter int addresswidth = AddrWidth,
    parameter int qdepth       = QDepth
);

    logic                          InValid;
    logic                          InReady;
    logic [addresswidth-1:0]       InRegister;
    logic [width-1:0]              InData;
    logic                          WbEnable;
    logic                          RegWrite;
    logic [addresswidth-1:0]       WriteRegister;
    logic [width-1:0]              WriteData;
    logic [addresswidth-1:0]       ReadRegister1;
    logic [addresswidth-1:0]       ReadRegister2;
    logic                          FwdValid1;
    logic                          FwdValid2;
    logic [width-1:0]              FwdData1;
    logic [width-1:0]              FwdData2;
    logic [countWidth(qdepth)-1:0] Count;
    logic                          Empty;
    logic                          Full;

    modport slave (
        input  InValid, InRegister, InData, WbEnable, ReadRegister1, ReadRegister2,
        output InReady, RegWrite, WriteRegister, WriteData,
        output FwdValid1, FwdValid2, FwdData1, FwdData2, Count, Empty, Full
    );

    modport master (
        output InValid, InRegister, InData, WbEnable, ReadRegister1, ReadRegister2,
        input  InReady, RegWrite, WriteRegister, WriteData,
        input  FwdValid1, FwdValid2, FwdData1, FwdData2, Count, Empty, Full
    );

endinterface

// File: rtl/writeback_queue_fwd.sv
// Youngest-match search of one read address over the occupied queue entries.
// Purely combinational; never matches address 0 and returns 0 data on a miss.
module fwd_match
    import writeback_queue_pkg::*;
#(
    parameter int width        = DataWidth,
    parameter int addresswidth = AddrWidth,
    parameter int qdepth       = QDepth
)(
    input  entry_t                        entries [qdepth],
    input  logic [$clog2(qdepth)-1:0]     head,
    input  logic [countWidth(qdepth)-1:0] count,
    input  logic [addresswidth-1:0]       readRegister,
    output logic                          fwdValid,
    output logic [width-1:0]              fwdData
);

    localparam int PtrWidth = $clog2(qdepth);
    localparam int CntWidth = countWidth(qdepth);

    logic [PtrWidth-1:0] idx;

    // Walk oldest to youngest so a later hit overrides an earlier one.
    always_comb begin
        fwdValid = 1'b0;
        fwdData  = '0;
        idx      = '0;
        for (int k = 0; k < qdepth; k++) begin
            idx = head + PtrWidth'(k);
            if ((CntWidth'(k) < count) && (readRegister != '0) &&
                (entries[idx].regAddr == readRegister)) begin
                fwdValid = 1'b1;
                fwdData  = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Circular queue of pending register writes, drained one per cycle while WbEnable, with read forwarding.
// Latency: enqueue at edge N is at the head from edge N; backpressure: InReady = !Full, no enqueue while full.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int width        = DataWidth,
    parameter int addresswidth = AddrWidth,
    parameter int qdepth       = QDepth
)(
    input  logic               Clk,
    input  logic               Reset_n,
    writeback_queue_if.slave   bus
);

    localparam int PtrWidth = $clog2(qdepth);
    localparam int CntWidth = countWidth(qdepth);

    entry_t              entries [qdepth];
    logic [PtrWidth-1:0] head;
    logic [PtrWidth-1:0] tail;
    logic [CntWidth-1:0] count;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;

    assign empty = (count == '0);
    assign full  = (count == CntWidth'(qdepth));

    // Writes to register 0 complete the handshake but are never stored.
    assign push = bus.InValid && !full && (bus.InRegister != '0);
    assign pop  = !empty && bus.WbEnable;

    assign bus.InReady       = !full;
    assign bus.Empty         = empty;
    assign bus.Full          = full;
    assign bus.Count         = count;
    assign bus.RegWrite      = pop;
    assign bus.WriteRegister = empty ? '0 : entries[head].regAddr;
    assign bus.WriteData     = empty ? '0 : entries[head].data;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CntWidth'(push) - CntWidth'(pop);
        end
    end

    // Storage is left unreset: only slots inside [head, head+count) are ever read.
    always_ff @(posedge Clk) begin
        if (push) entries[tail] <= '{regAddr: bus.InRegister, data: bus.InData};
    end

    fwd_match #(.width(width), .addresswidth(addresswidth), .qdepth(qdepth)) u_fwd1 (
        .entries      (entries),
        .head         (head),
        .count        (count),
        .readRegister (bus.ReadRegister1),
        .fwdValid     (bus.FwdValid1),
        .fwdData      (bus.FwdData1)
    );

    fwd_match #(.width(width), .addresswidth(addresswidth), .qdepth(qdepth)) u_fwd2 (
        .entries      (entries),
        .head         (head),
        .count        (count),
        .readRegister (bus.ReadRegister2),
        .fwdValid     (bus.FwdValid2),
        .fwdData      (bus.FwdData2)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: a queue-based reference model checked every cycle plus literal expectations.
module tb_writeback_queue;

    localparam int QD = 4;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ment_t;

    logic  Clk = 1'b0;
    logic  Reset_n = 1'b0;
    int    checks = 0;
    int    passed = 0;
    ment_t mq[$];

    writeback_queue_if wbq();

    writeback_queue dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (wbq)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    endtask

    task automatic model_fwd(input logic [4:0] ra, output logic v, output logic [31:0] d);
        v = 1'b0;
        d = '0;
        if (ra != 5'd0) begin
            foreach (mq[i]) begin
                if (mq[i].r == ra) begin
                    v = 1'b1;
                    d = mq[i].d;
                end
            end
        end
    endtask

    // Reference queue: full is judged before any pop in the same cycle.
    always @(posedge Clk) begin
        if (Reset_n) begin
            automatic bit do_pop  = (mq.size() != 0) && wbq.WbEnable;
            automatic bit do_push = wbq.InValid && (mq.size() < QD) && (wbq.InRegister != 5'd0);
            automatic ment_t e;
            e.r = wbq.InRegister;
            e.d = wbq.InData;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
    end

    always @(negedge Reset_n) mq.delete();

    task automatic check_model();
        logic        v1, v2;
        logic [31:0] d1, d2;
        bit          emp;
        emp = (mq.size() == 0);
        model_fwd(wbq.ReadRegister1, v1, d1);
        model_fwd(wbq.ReadRegister2, v2, d2);
        chk("cmp_count",   wbq.Count,    mq.size());
        chk("cmp_empty",   wbq.Empty,    emp);
        chk("cmp_full",    wbq.Full,     mq.size() == QD);
        chk("cmp_inready", wbq.InReady,  mq.size() != QD);
        chk("cmp_regwrite", wbq.RegWrite, !emp && wbq.WbEnable);
        chk("cmp_wreg",    wbq.WriteRegister, emp ? 5'd0 : mq[0].r);
        chk("cmp_wdata",   wbq.WriteData,     emp ? 32'd0 : mq[0].d);
        chk("cmp_fwdv1",   wbq.FwdValid1, v1);
        chk("cmp_fwdd1",   wbq.FwdData1,  d1);
        chk("cmp_fwdv2",   wbq.FwdValid2, v2);
        chk("cmp_fwdd2",   wbq.FwdData2,  d2);
    endtask

    always @(negedge Clk) check_model();

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d);
        wbq.InValid    = v;
        wbq.InRegister = r;
        wbq.InData     = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 5'd0, 32'd0);
        wbq.WbEnable      = 1'b0;
        wbq.ReadRegister1 = 5'd0;
        wbq.ReadRegister2 = 5'd0;

        // Reset state
        tick();
        chk("rst_empty",   wbq.Empty,    1);
        chk("rst_inready", wbq.InReady,  1);
        chk("rst_count",   wbq.Count,    0);
        chk("rst_regwrite", wbq.RegWrite, 0);
        tick();
        Reset_n = 1'b1;
        tick();

        // Single enqueue, no drain, forwarded on port 1
        wbq.ReadRegister1 = 5'd3;
        drive(1'b1, 5'd3, 32'hAAAA0001);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        chk("r40_count",    wbq.Count,     1);
        chk("r40_fwdv1",    wbq.FwdValid1, 1);
        chk("r40_fwdd1",    wbq.FwdData1,  32'hAAAA0001);
        chk("r40_regwrite", wbq.RegWrite,  0);
        chk("r40_model",    mq.size(),     1);

        // Youngest match wins, then drain in order
        drive(1'b1, 5'd5, 32'h11);
        tick();
        drive(1'b1, 5'd5, 32'h22);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        wbq.ReadRegister2 = 5'd5;
        #1;
        chk("r41_fwdv2",  wbq.FwdValid2, 1);
        chk("r41_fwdd2",  wbq.FwdData2,  32'h22);
        chk("r41_count",  wbq.Count,     3);
        wbq.WbEnable = 1'b1;
        #1;
        chk("r41_rw0",    wbq.RegWrite,      1);
        chk("r41_wreg0",  wbq.WriteRegister, 3);
        tick();
        chk("r41_rw1",    wbq.RegWrite,  1);
        chk("r41_wd1",    wbq.WriteData, 32'h11);
        tick();
        chk("r41_rw2",    wbq.RegWrite,  1);
        chk("r41_wd2",    wbq.WriteData, 32'h22);
        chk("r41_popfwd", wbq.FwdData2,  32'h22);
        tick();
        chk("r41_empty",  wbq.Empty,     1);
        chk("r41_rw3",    wbq.RegWrite,  0);
        chk("r41_fwdv2b", wbq.FwdValid2, 0);
        wbq.WbEnable = 1'b0;

        // Fill to full, fifth write stalls, drain with InValid held
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'h100 + 32'(i));
            tick();
        end
        drive(1'b1, 5'd7, 32'h777);
        #1;
        chk("r42_full",    wbq.Full,    1);
        chk("r42_inready", wbq.InReady, 0);
        chk("r42_count",   wbq.Count,   4);
        tick();
        chk("r42_reject",  wbq.Count,   4);
        wbq.WbEnable = 1'b1;
        #1;
        chk("r42_hold",    wbq.Count,     4);
        chk("r42_rw",      wbq.RegWrite,  1);
        chk("r42_wd",      wbq.WriteData, 32'h101);
        tick();
        chk("r42_nopush",  wbq.Count,   3);
        chk("r42_ready",   wbq.InReady, 1);
        tick();
        chk("r42_pair",    wbq.Count,   3);
        drive(1'b0, 5'd0, 32'd0);
        for (int n = 0; n < 20 && !wbq.Empty; n++) tick();
        chk("r42_drained", wbq.Empty, 1);
        wbq.WbEnable = 1'b0;

        // Register 0 handshakes but is discarded; address 0 never forwards
        wbq.ReadRegister1 = 5'd0;
        drive(1'b1, 5'd0, 32'hDEAD);
        #1;
        chk("r43_ready", wbq.InReady, 1);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        chk("r43_count", wbq.Count,     0);
        chk("r43_fwdv1", wbq.FwdValid1, 0);

        // Asynchronous reset with entries pending
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(9 + i), 32'hC0 + 32'(i));
            tick();
        end
        drive(1'b0, 5'd0, 32'd0);
        wbq.ReadRegister1 = 5'd10;
        #1;
        chk("r44_pre_fwdv1", wbq.FwdValid1, 1);
        chk("r44_pre_count", wbq.Count,     3);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("r44_count",   wbq.Count,         0);
        chk("r44_empty",   wbq.Empty,         1);
        chk("r44_full",    wbq.Full,          0);
        chk("r44_inready", wbq.InReady,       1);
        chk("r44_fwdv1",   wbq.FwdValid1,     0);
        chk("r44_fwdd1",   wbq.FwdData1,      0);
        chk("r44_wreg",    wbq.WriteRegister, 0);
        chk("r44_wdata",   wbq.WriteData,     0);
        wbq.WbEnable = 1'b1;
        #1;
        chk("r44_rw_in_rst", wbq.RegWrite, 0);
        tick();
        tick();
        Reset_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("r44_post_rw",    wbq.RegWrite, 0);
            chk("r44_post_count", wbq.Count,    0);
        end

        // Streaming pairs across several pointer wraps
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 5'((i % 31) + 1), 32'h1111 * 32'(i + 1));
            tick();
            chk("r45_rw",    wbq.RegWrite,      1);
            chk("r45_wreg",  wbq.WriteRegister, 5'((i % 31) + 1));
            chk("r45_wdata", wbq.WriteData,     32'h1111 * 32'(i + 1));
            chk("r45_count", wbq.Count,         1);
        end
        drive(1'b0, 5'd0, 32'd0);
        tick();
        chk("r45_empty", wbq.Empty, 1);
        wbq.WbEnable = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter width, default 32: data width of each queued write.
REQ-002 SHALL have parameter addresswidth, default 5: register address width.
REQ-003 SHALL have parameter qdepth, default 4: queue entries, a power of two >= 2.
REQ-004 SHALL have port Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port InValid, input, 1 bit: upstream result present.
REQ-007 SHALL have port InReady, output, 1 bit: queue accepts this cycle.
REQ-008 SHALL have port InRegister, input, addresswidth bits: destination register.
REQ-009 SHALL have port InData, input, width bits: result value.
REQ-010 SHALL have port WbEnable, input, 1 bit: drain permission from the pipeline controller.
REQ-011 SHALL have port RegWrite, output, 1 bit: write strobe to the register file.
REQ-012 SHALL have port WriteRegister, output, addresswidth bits: register-file write address.
REQ-013 SHALL have port WriteData, output, width bits: register-file write data.
REQ-014 SHALL have ports ReadRegister1 and ReadRegister2, input, addresswidth bits each: read addresses snooped from the register file.
REQ-015 SHALL have ports FwdValid1 and FwdValid2, output, 1 bit each: a pending write matches the corresponding read address.
REQ-016 SHALL have ports FwdData1 and FwdData2, output, width bits each: forwarded value.
REQ-017 SHALL have port Count, output, log2(qdepth)+1 bits: occupied entries.
REQ-018 SHALL have ports Empty and Full, output, 1 bit each: Count==0 and Count==qdepth.

Function
REQ-019 SHALL hold the queue as a circular buffer with head/tail pointers wrapping modulo qdepth.
REQ-020 SHALL drive InReady = !Full, combinationally.
REQ-021 SHALL count an enqueue handshake when InValid && InReady at a rising edge.
REQ-022 SHALL discard handshaked writes with InRegister==0, storing no entry and leaving Count unchanged.
REQ-023 SHALL drive RegWrite = !Empty && WbEnable, with WriteRegister/WriteData taken from the head entry.
REQ-024 SHALL force WriteRegister and WriteData to 0 whenever Empty.
REQ-025 SHALL pop the head at every rising edge where RegWrite==1, for a drain latency of one entry per cycle.
REQ-026 SHALL, on a simultaneous enqueue and pop, keep Count unchanged and advance both pointers.
REQ-027 SHALL, when full, accept no enqueue even if a pop occurs in the same cycle.
REQ-028 SHALL give a minimum enqueue-to-RegWrite latency of one cycle: an entry enqueued at edge N appears at the head from edge N.
REQ-029 SHALL compute forwarding combinationally over occupied entries only, excluding the same-cycle InData.
REQ-030 SHALL select the youngest matching entry when several entries match.
REQ-031 SHALL never assert forwarding for read address 0.
REQ-032 SHALL drive FwdData to 0 whenever the corresponding FwdValid is 0.
REQ-033 SHALL, when the head is popping, still report that head entry as a forwarding source in that cycle.

Reset
REQ-034 SHALL, on Reset_n low and asynchronously, clear both pointers and Count.
REQ-035 SHALL, while Reset_n is low, hold RegWrite=0, WriteRegister=0, WriteData=0, FwdValid1/2=0, FwdData1/2=0, Empty=1, Full=0, InReady=1.
REQ-036 SHALL drop any entries pending when reset is asserted mid-operation, issuing no further RegWrite for them.
REQ-037 SHALL leave entry storage unreset, with its contents unobservable while not occupied.

Structure
REQ-038 SHALL define the qdepth and address/data width constants and the entry record type (register, data) in the shared CPU package.
REQ-039 SHALL implement the youngest-match search as one sub-module, fwd_match, instantiated once per read port.

Verification
REQ-040 Bench SHALL cover: reset, then enqueue (3, 0xAAAA0001) with WbEnable=0 -> Count=1, FwdValid1=1 with FwdData1=0xAAAA0001 for ReadRegister1=3, RegWrite=0.
REQ-041 Bench SHALL cover: enqueue (5, 0x11) then (5, 0x22) -> FwdData2=0x22 for ReadRegister2=5; raise WbEnable -> RegWrite pulses for 0x11 then 0x22 on consecutive cycles, then Empty=1.
REQ-042 Bench SHALL cover: hold WbEnable=0 and enqueue 4 entries -> Full=1, InReady=0, a fifth InValid is not accepted; raise WbEnable with InValid held -> Count stays 4 for one cycle, then drains.
REQ-043 Bench SHALL cover: enqueue (0, 0xDEAD) -> handshake completes, Count unchanged; ReadRegister1=0 -> FwdValid1=0.
REQ-044 Bench SHALL cover: 3 entries pending, Reset_n pulsed low mid-cycle -> outputs cleared immediately, and after release no RegWrite occurs and Count=0.
REQ-045 Bench SHALL cover: more than 2*qdepth enqueue/pop pairs -> pointer wrap-around, with writes reaching the register file in FIFO order.
